// File: rtl/reserve_station_pkg.sv
// Shared widths, zero constants, opcode encodings and the CDB operand snoop helper
// for the arithmetic reservation station.
package reserve_station_pkg;

    localparam int OPERATOR_WIDTH = 6;
    localparam int ROB_WIDTH      = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int ADDRESS_WIDTH  = 32;
    localparam int DEF_RS_SIZE    = 16;

    localparam logic [DATA_WIDTH-1:0]     ZERO_DATA = '0;
    localparam logic [ADDRESS_WIDTH-1:0]  ZERO_ADDR = '0;
    localparam logic [ROB_WIDTH-1:0]      ZERO_ROB  = '0;
    localparam logic [OPERATOR_WIDTH-1:0] ZERO_OP   = '0;

    typedef enum logic [OPERATOR_WIDTH-1:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_AND   = 6'd3,
        OP_OR    = 6'd4,
        OP_XOR   = 6'd5,
        OP_SLL   = 6'd6,
        OP_SRL   = 6'd7,
        OP_SRA   = 6'd8,
        OP_SLT   = 6'd9,
        OP_SLTU  = 6'd10,
        OP_LUI   = 6'd11,
        OP_AUIPC = 6'd12,
        OP_JAL   = 6'd13,
        OP_JALR  = 6'd14,
        OP_BEQ   = 6'd15,
        OP_BNE   = 6'd16,
        OP_BLT   = 6'd17,
        OP_BGE   = 6'd18,
        OP_BLTU  = 6'd19,
        OP_BGEU  = 6'd20
    } op_e;

    typedef struct packed {
        logic                  busy;
        logic [ROB_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] val;
    } operand_t;

    typedef struct packed {
        logic                      busy;
        logic [OPERATOR_WIDTH-1:0] op;
        logic [ADDRESS_WIDTH-1:0]  pc;
        logic [DATA_WIDTH-1:0]     imm;
        operand_t                  j;
        operand_t                  k;
        logic [ROB_WIDTH-1:0]      reorder;
    } rs_entry_t;

    // ALU broadcast takes precedence when both buses carry the same tag.
    function automatic operand_t snoop(
        input operand_t              opnd,
        input logic                  alu_en,
        input logic [ROB_WIDTH-1:0]  alu_tag,
        input logic [DATA_WIDTH-1:0] alu_val,
        input logic                  lsb_en,
        input logic [ROB_WIDTH-1:0]  lsb_tag,
        input logic [DATA_WIDTH-1:0] lsb_val
    );
        operand_t r;
        r = opnd;
        if (opnd.busy) begin
            if (alu_en && alu_tag == opnd.tag) begin
                r.val  = alu_val;
                r.busy = 1'b0;
            end else if (lsb_en && lsb_tag == opnd.tag) begin
                r.val  = lsb_val;
                r.busy = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reserve_station_rs_select.sv
// Priority encoder: lowest free slot, and the ready slot to dispatch.
// RS_AGE_PRIORITY_EN selects the oldest ready slot (ties to lowest index).
module rs_select #(
    parameter int RS_SIZE  = 16,
    parameter int RS_IDX_W = 4
) (
    input  logic [RS_SIZE-1:0]          busy,
    input  logic [RS_SIZE-1:0]          ready,
`ifdef RS_AGE_PRIORITY_EN
    input  logic [RS_SIZE*RS_IDX_W-1:0] age,
`endif
    output logic [RS_IDX_W-1:0]         free_idx,
    output logic                        free_valid,
    output logic [RS_IDX_W-1:0]         sel_idx,
    output logic                        sel_valid
);

`ifdef RS_AGE_PRIORITY_EN
    logic [RS_IDX_W-1:0] best_age;
    logic [RS_IDX_W-1:0] cur_age;
`endif

    always_comb begin
        free_idx   = '0;
        free_valid = 1'b0;
        sel_idx    = '0;
        sel_valid  = 1'b0;
`ifdef RS_AGE_PRIORITY_EN
        best_age   = '0;
        cur_age    = '0;
`endif
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!busy[i] && !free_valid) begin
                free_idx   = RS_IDX_W'(i);
                free_valid = 1'b1;
            end
`ifdef RS_AGE_PRIORITY_EN
            cur_age = age[i*RS_IDX_W +: RS_IDX_W];
            if (ready[i] && (!sel_valid || cur_age > best_age)) begin
                sel_idx   = RS_IDX_W'(i);
                sel_valid = 1'b1;
                best_age  = cur_age;
            end
`else
            if (ready[i] && !sel_valid) begin
                sel_idx   = RS_IDX_W'(i);
                sel_valid = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/reserve_station.sv
// Arithmetic reservation station in front of the ALU: issue with CDB bypass,
// CDB wakeup, one registered dispatch per cycle. Optional: RS_AGE_PRIORITY_EN.
module reserve_station
    import reserve_station_pkg::*;
#(
    parameter int RS_SIZE  = DEF_RS_SIZE,
    parameter int RS_IDX_W = 4
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic                      in_rdy,
    input  logic                      in_clear,
    input  logic                      in_issue_enable,
    input  logic [OPERATOR_WIDTH-1:0] in_issue_type,
    input  logic [ADDRESS_WIDTH-1:0]  in_issue_pc,
    input  logic [DATA_WIDTH-1:0]     in_issue_imm,
    input  logic [DATA_WIDTH-1:0]     in_issue_vj,
    input  logic [DATA_WIDTH-1:0]     in_issue_vk,
    input  logic                      in_issue_qj_busy,
    input  logic                      in_issue_qk_busy,
    input  logic [ROB_WIDTH-1:0]      in_issue_qj,
    input  logic [ROB_WIDTH-1:0]      in_issue_qk,
    input  logic [ROB_WIDTH-1:0]      in_issue_reorder,
    output logic                      out_full,
    input  logic                      in_alu_cdb_enable,
    input  logic [ROB_WIDTH-1:0]      in_alu_cdb_reorder,
    input  logic [DATA_WIDTH-1:0]     in_alu_cdb_result,
    input  logic                      in_lsb_cdb_enable,
    input  logic [ROB_WIDTH-1:0]      in_lsb_cdb_reorder,
    input  logic [DATA_WIDTH-1:0]     in_lsb_cdb_result,
    output logic                      out_alu_enable,
    output logic [OPERATOR_WIDTH-1:0] out_alu_type,
    output logic [ADDRESS_WIDTH-1:0]  out_alu_pc,
    output logic [DATA_WIDTH-1:0]     out_alu_imm,
    output logic [DATA_WIDTH-1:0]     out_alu_rs,
    output logic [DATA_WIDTH-1:0]     out_alu_rt,
    output logic [ROB_WIDTH-1:0]      out_alu_reorder
);

    rs_entry_t            ent [RS_SIZE];
    logic [RS_SIZE-1:0]   busy_vec;
    logic [RS_SIZE-1:0]   ready_vec;
    logic [RS_IDX_W-1:0]  free_idx;
    logic [RS_IDX_W-1:0]  sel_idx;
    logic                 free_valid;
    logic                 sel_valid;
    operand_t             issue_j;
    operand_t             issue_k;
    logic                 do_issue;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy & ~ent[i].j.busy & ~ent[i].k.busy;
        end
    end

    always_comb begin
        issue_j = snoop({in_issue_qj_busy, in_issue_qj, in_issue_vj},
                        in_alu_cdb_enable, in_alu_cdb_reorder, in_alu_cdb_result,
                        in_lsb_cdb_enable, in_lsb_cdb_reorder, in_lsb_cdb_result);
        issue_k = snoop({in_issue_qk_busy, in_issue_qk, in_issue_vk},
                        in_alu_cdb_enable, in_alu_cdb_reorder, in_alu_cdb_result,
                        in_lsb_cdb_enable, in_lsb_cdb_reorder, in_lsb_cdb_result);
    end

    assign out_full = ~free_valid;
    assign do_issue = in_issue_enable & free_valid;

`ifdef RS_AGE_PRIORITY_EN
    logic [RS_IDX_W-1:0]         age [RS_SIZE];
    logic [RS_SIZE*RS_IDX_W-1:0] age_flat;

    always_comb begin
        age_flat = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            age_flat[i*RS_IDX_W +: RS_IDX_W] = age[i];
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) age[i] <= '0;
        end else if (in_rdy && !in_clear) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (ent[i].busy && age[i] != '1) age[i] <= age[i] + 1'b1;
            end
            if (do_issue) age[free_idx] <= '0;
        end
    end
`endif

    rs_select #(
        .RS_SIZE  (RS_SIZE),
        .RS_IDX_W (RS_IDX_W)
    ) u_select (
        .busy       (busy_vec),
        .ready      (ready_vec),
`ifdef RS_AGE_PRIORITY_EN
        .age        (age_flat),
`endif
        .free_idx   (free_idx),
        .free_valid (free_valid),
        .sel_idx    (sel_idx),
        .sel_valid  (sel_valid)
    );

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) ent[i] <= '0;
            out_alu_enable  <= 1'b0;
            out_alu_type    <= ZERO_OP;
            out_alu_pc      <= ZERO_ADDR;
            out_alu_imm     <= ZERO_DATA;
            out_alu_rs      <= ZERO_DATA;
            out_alu_rt      <= ZERO_DATA;
            out_alu_reorder <= ZERO_ROB;
        end else if (!in_rdy) begin
            out_alu_enable <= 1'b0;
        end else if (in_clear) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
            out_alu_enable <= 1'b0;
        end else begin
            out_alu_enable <= sel_valid;
            if (sel_valid) begin
                out_alu_type    <= ent[sel_idx].op;
                out_alu_pc      <= ent[sel_idx].pc;
                out_alu_imm     <= ent[sel_idx].imm;
                out_alu_rs      <= ent[sel_idx].j.val;
                out_alu_rt      <= ent[sel_idx].k.val;
                out_alu_reorder <= ent[sel_idx].reorder;
            end
            // The issue slot is free and the dispatched slot is ready, so they never collide.
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (ent[i].busy) begin
                    ent[i].j <= snoop(ent[i].j,
                                      in_alu_cdb_enable, in_alu_cdb_reorder, in_alu_cdb_result,
                                      in_lsb_cdb_enable, in_lsb_cdb_reorder, in_lsb_cdb_result);
                    ent[i].k <= snoop(ent[i].k,
                                      in_alu_cdb_enable, in_alu_cdb_reorder, in_alu_cdb_result,
                                      in_lsb_cdb_enable, in_lsb_cdb_reorder, in_lsb_cdb_result);
                    if (sel_valid && sel_idx == RS_IDX_W'(i)) ent[i].busy <= 1'b0;
                end
            end
            if (do_issue) begin
                ent[free_idx] <= '{busy:    1'b1,
                                   op:      in_issue_type,
                                   pc:      in_issue_pc,
                                   imm:     in_issue_imm,
                                   j:       issue_j,
                                   k:       issue_k,
                                   reorder: in_issue_reorder};
            end
        end
    end

endmodule

// File: tb/tb_reserve_station.sv
// Self-checking bench for reserve_station: directed scenarios followed by random
// traffic, all compared against a slot-level reference model kept in this file.
module tb_reserve_station;
    import reserve_station_pkg::*;

    localparam int N = 16;

    logic                      in_clk;
    logic                      in_rst;
    logic                      in_rdy;
    logic                      in_clear;
    logic                      in_issue_enable;
    logic [OPERATOR_WIDTH-1:0] in_issue_type;
    logic [ADDRESS_WIDTH-1:0]  in_issue_pc;
    logic [DATA_WIDTH-1:0]     in_issue_imm;
    logic [DATA_WIDTH-1:0]     in_issue_vj;
    logic [DATA_WIDTH-1:0]     in_issue_vk;
    logic                      in_issue_qj_busy;
    logic                      in_issue_qk_busy;
    logic [ROB_WIDTH-1:0]      in_issue_qj;
    logic [ROB_WIDTH-1:0]      in_issue_qk;
    logic [ROB_WIDTH-1:0]      in_issue_reorder;
    logic                      out_full;
    logic                      in_alu_cdb_enable;
    logic [ROB_WIDTH-1:0]      in_alu_cdb_reorder;
    logic [DATA_WIDTH-1:0]     in_alu_cdb_result;
    logic                      in_lsb_cdb_enable;
    logic [ROB_WIDTH-1:0]      in_lsb_cdb_reorder;
    logic [DATA_WIDTH-1:0]     in_lsb_cdb_result;
    logic                      out_alu_enable;
    logic [OPERATOR_WIDTH-1:0] out_alu_type;
    logic [ADDRESS_WIDTH-1:0]  out_alu_pc;
    logic [DATA_WIDTH-1:0]     out_alu_imm;
    logic [DATA_WIDTH-1:0]     out_alu_rs;
    logic [DATA_WIDTH-1:0]     out_alu_rt;
    logic [ROB_WIDTH-1:0]      out_alu_reorder;

    reserve_station #(.RS_SIZE(N), .RS_IDX_W(4)) dut (
        .in_clk             (in_clk),
        .in_rst             (in_rst),
        .in_rdy             (in_rdy),
        .in_clear           (in_clear),
        .in_issue_enable    (in_issue_enable),
        .in_issue_type      (in_issue_type),
        .in_issue_pc        (in_issue_pc),
        .in_issue_imm       (in_issue_imm),
        .in_issue_vj        (in_issue_vj),
        .in_issue_vk        (in_issue_vk),
        .in_issue_qj_busy   (in_issue_qj_busy),
        .in_issue_qk_busy   (in_issue_qk_busy),
        .in_issue_qj        (in_issue_qj),
        .in_issue_qk        (in_issue_qk),
        .in_issue_reorder   (in_issue_reorder),
        .out_full           (out_full),
        .in_alu_cdb_enable  (in_alu_cdb_enable),
        .in_alu_cdb_reorder (in_alu_cdb_reorder),
        .in_alu_cdb_result  (in_alu_cdb_result),
        .in_lsb_cdb_enable  (in_lsb_cdb_enable),
        .in_lsb_cdb_reorder (in_lsb_cdb_reorder),
        .in_lsb_cdb_result  (in_lsb_cdb_result),
        .out_alu_enable     (out_alu_enable),
        .out_alu_type       (out_alu_type),
        .out_alu_pc         (out_alu_pc),
        .out_alu_imm        (out_alu_imm),
        .out_alu_rs         (out_alu_rs),
        .out_alu_rt         (out_alu_rt),
        .out_alu_reorder    (out_alu_reorder)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Reference model: one record per slot; age derives from the issue timestamp.
    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] imm;
        bit          jb;
        bit          kb;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  rob;
        int unsigned t;
    } m_ent_t;

    m_ent_t       m [N];
    logic         m_en;
    logic [137:0] m_pay;
    int unsigned  act_cnt;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int unsigned m_age(input int i);
        int unsigned d;
        d = act_cnt - m[i].t - 1;
        return (d > 15) ? 15 : d;
    endfunction

    function automatic logic [32:0] resolved(input bit b, input logic [3:0] q, input logic [31:0] v);
        if (b && in_alu_cdb_enable && in_alu_cdb_reorder == q) return {1'b0, in_alu_cdb_result};
        if (b && in_lsb_cdb_enable && in_lsb_cdb_reorder == q) return {1'b0, in_lsb_cdb_result};
        return {b, v};
    endfunction

    task automatic model_edge();
        int fi;
        int s;
        fi = -1;
        s  = -1;
        if (!in_rst) begin
            for (int i = 0; i < N; i++) m[i].busy = 1'b0;
            m_en    = 1'b0;
            m_pay   = '0;
            act_cnt = 0;
        end else if (!in_rdy) begin
            m_en = 1'b0;
        end else if (in_clear) begin
            for (int i = 0; i < N; i++) m[i].busy = 1'b0;
            m_en = 1'b0;
            act_cnt++;
        end else begin
            for (int i = 0; i < N; i++) if (!m[i].busy && fi < 0) fi = i;
            for (int i = 0; i < N; i++) begin
                if (m[i].busy && !m[i].jb && !m[i].kb) begin
`ifdef RS_AGE_PRIORITY_EN
                    if (s < 0 || m_age(i) > m_age(s)) s = i;
`else
                    if (s < 0) s = i;
`endif
                end
            end
            m_en = (s >= 0);
            if (s >= 0) begin
                m_pay = {m[s].op, m[s].pc, m[s].imm, m[s].vj, m[s].vk, m[s].rob};
                m[s].busy = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (m[i].busy) begin
                    {m[i].jb, m[i].vj} = resolved(m[i].jb, m[i].qj, m[i].vj);
                    {m[i].kb, m[i].vk} = resolved(m[i].kb, m[i].qk, m[i].vk);
                end
            end
            if (in_issue_enable && fi >= 0) begin
                m[fi].busy = 1'b1;
                m[fi].op   = in_issue_type;
                m[fi].pc   = in_issue_pc;
                m[fi].imm  = in_issue_imm;
                m[fi].qj   = in_issue_qj;
                m[fi].qk   = in_issue_qk;
                m[fi].rob  = in_issue_reorder;
                m[fi].t    = act_cnt;
                {m[fi].jb, m[fi].vj} = resolved(in_issue_qj_busy, in_issue_qj, in_issue_vj);
                {m[fi].kb, m[fi].vk} = resolved(in_issue_qk_busy, in_issue_qk, in_issue_vk);
            end
            act_cnt++;
        end
    endtask

    task automatic compare_all();
        check("alu_enable", out_alu_enable, m_en);
        check("full", out_full, m_full());
        check("alu_payload", {out_alu_type, out_alu_pc, out_alu_imm, out_alu_rs, out_alu_rt, out_alu_reorder}, m_pay);
    endtask

    task automatic tick();
        @(posedge in_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        in_rst             = 1'b1;
        in_rdy             = 1'b1;
        in_clear           = 1'b0;
        in_issue_enable    = 1'b0;
        in_alu_cdb_enable  = 1'b0;
        in_lsb_cdb_enable  = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic jb, input logic [3:0] qj, input logic kb, input logic [3:0] qk,
                         input logic [3:0] rob);
        in_issue_enable  = 1'b1;
        in_issue_type    = op;
        in_issue_pc      = $urandom;
        in_issue_imm     = $urandom;
        in_issue_vj      = vj;
        in_issue_vk      = vk;
        in_issue_qj_busy = jb;
        in_issue_qj      = qj;
        in_issue_qk_busy = kb;
        in_issue_qk      = qk;
        in_issue_reorder = rob;
    endtask

    task automatic alu_cdb(input logic [3:0] tag, input logic [31:0] val);
        in_alu_cdb_enable  = 1'b1;
        in_alu_cdb_reorder = tag;
        in_alu_cdb_result  = val;
    endtask

    logic [3:0] first_rob;
    logic [3:0] second_rob;

    initial begin
        idle();
        in_issue_type = '0; in_issue_pc = '0; in_issue_imm = '0;
        in_issue_vj = '0; in_issue_vk = '0; in_issue_qj_busy = 1'b0; in_issue_qk_busy = 1'b0;
        in_issue_qj = '0; in_issue_qk = '0; in_issue_reorder = '0;
        in_alu_cdb_reorder = '0; in_alu_cdb_result = '0;
        in_lsb_cdb_reorder = '0; in_lsb_cdb_result = '0;
        for (int i = 0; i < N; i++) m[i] = '{default: 0};
        m_en = 1'b0; m_pay = '0; act_cnt = 0;

        // Reset state
        in_rst = 1'b0;
        tick();
        tick();
        check("reset_enable", out_alu_enable, 1'b0);
        check("reset_full", out_full, 1'b0);
        check("reset_rs", out_alu_rs, 32'h0);
        in_rst = 1'b1;

        // Ready issue: never dispatched in its own issue cycle
        issue(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick();
        check("ready_issue_same_cycle", out_alu_enable, 1'b0);
        idle();
        tick();
        check("ready_issue_enable", out_alu_enable, 1'b1);
        check("ready_issue_rs", out_alu_rs, 32'd5);
        check("ready_issue_rt", out_alu_rt, 32'd7);
        check("ready_issue_reorder", out_alu_reorder, 4'd3);
        tick();
        check("ready_issue_gone", out_alu_enable, 1'b0);

        // Wakeup from ALU CDB
        issue(OP_SUB, 32'd0, 32'd1, 1'b1, 4'd9, 1'b0, 4'd0, 4'd4);
        tick();
        idle();
        tick();
        alu_cdb(4'd9, 32'h10);
        tick();
        check("wakeup_edge_no_dispatch", out_alu_enable, 1'b0);
        idle();
        tick();
        check("wakeup_enable", out_alu_enable, 1'b1);
        check("wakeup_rs", out_alu_rs, 32'h10);
        check("wakeup_reorder", out_alu_reorder, 4'd4);

        // Same-cycle bypass from LSB CDB
        issue(OP_ADD, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd5);
        in_lsb_cdb_enable  = 1'b1;
        in_lsb_cdb_reorder = 4'd2;
        in_lsb_cdb_result  = 32'hAB;
        tick();
        check("bypass_same_cycle", out_alu_enable, 1'b0);
        idle();
        tick();
        check("bypass_enable", out_alu_enable, 1'b1);
        check("bypass_rt", out_alu_rt, 32'hAB);

        // Fill every slot with a pending operand
        for (int i = 0; i < N; i++) begin
            issue(OP_ADD, 32'(i), 32'd0, 1'b1, 4'(i), 1'b0, 4'd0, 4'(i));
            tick();
        end
        check("full_after_16", out_full, 1'b1);
        issue(OP_XOR, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        if (out_full) $display("note: protocol error, issue attempted while full (dropped)");
        tick();
        check("full_after_drop", out_full, 1'b1);
        idle();
        alu_cdb(4'd0, 32'h55);
        tick();
        check("full_on_wake_edge", out_full, 1'b1);
        idle();
        tick();
        check("full_drain_enable", out_alu_enable, 1'b1);
        check("full_drain_reorder", out_alu_reorder, 4'd0);
        check("full_drain_rs", out_alu_rs, 32'h55);
        check("full_released", out_full, 1'b0);

        // Clear drops the remaining pending entries
        in_clear = 1'b1;
        tick();
        check("clear_enable", out_alu_enable, 1'b0);
        check("clear_full", out_full, 1'b0);
        idle();
        alu_cdb(4'd3, 32'h33);
        tick();
        idle();
        tick();
        check("clear_stale_tag", out_alu_enable, 1'b0);

        // Ordering: slot 5 pending since long ago, slot 0 refilled later, both woken together
        issue(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            issue(OP_ADD, 32'd0, 32'd0, 1'b1, 4'(i + 7), 1'b0, 4'd0, 4'(i));
            tick();
        end
        issue(OP_OR, 32'd0, 32'd2, 1'b1, 4'd7, 1'b0, 4'd0, 4'd5);
        tick();
        idle();
        alu_cdb(4'd12, 32'd1);
        tick();
        idle();
        tick();
        check("order_filler_reorder", out_alu_reorder, 4'd0);
        issue(OP_AND, 32'd0, 32'd6, 1'b1, 4'd7, 1'b0, 4'd0, 4'd6);
        tick();
        idle();
        alu_cdb(4'd7, 32'h77);
        tick();
        idle();
`ifdef RS_AGE_PRIORITY_EN
        first_rob  = 4'd5;
        second_rob = 4'd6;
`else
        first_rob  = 4'd6;
        second_rob = 4'd5;
`endif
        tick();
        check("order_first_enable", out_alu_enable, 1'b1);
        check("order_first_reorder", out_alu_reorder, first_rob);
        tick();
        check("order_second_enable", out_alu_enable, 1'b1);
        check("order_second_reorder", out_alu_reorder, second_rob);
        tick();
        check("order_done", out_alu_enable, 1'b0);
        in_clear = 1'b1;
        tick();
        idle();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_rst   = ($urandom_range(0, 199) != 0);
            in_rdy   = ($urandom_range(0, 9) != 0);
            in_clear = ($urandom_range(0, 49) == 0);
            in_issue_enable  = !m_full() && ($urandom_range(0, 9) < 7);
            in_issue_type    = 6'($urandom_range(1, 20));
            in_issue_pc      = $urandom;
            in_issue_imm     = $urandom;
            in_issue_vj      = $urandom;
            in_issue_vk      = $urandom;
            in_issue_qj_busy = $urandom_range(0, 1) == 1;
            in_issue_qk_busy = $urandom_range(0, 3) == 0;
            in_issue_qj      = 4'($urandom_range(0, 15));
            in_issue_qk      = 4'($urandom_range(0, 15));
            in_issue_reorder = 4'($urandom_range(0, 15));
            in_alu_cdb_enable  = $urandom_range(0, 9) < 3;
            in_alu_cdb_reorder = 4'($urandom_range(0, 15));
            in_alu_cdb_result  = $urandom;
            in_lsb_cdb_enable  = $urandom_range(0, 9) < 3;
            in_lsb_cdb_reorder = ($urandom_range(0, 3) == 0) ? in_alu_cdb_reorder : 4'($urandom_range(0, 15));
            in_lsb_cdb_result  = $urandom;
            tick();
        end
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
